// File: rtl/spi_adc_responder_if.sv
// Four-wire SPI bus between the ADC controller (master) and the ADC stand-in (slave).
// The master drives SCK, CS_N and MOSI; the slave drives MISO.
interface spi_adc_responder_if;
    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_sck, output spi_cs_n, output spi_mosi, input spi_miso);
    modport slave  (input spi_sck, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_adc_responder.sv
// AD7908-style 8-bit ADC responder: decodes the 12-bit control word on MOSI
// and returns 16-bit conversion frames on MISO with a one-frame channel pipeline.
module spi_adc_responder #(
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_adc_responder_if.slave    spi,
    input  logic [8*NUM_CH-1:0]   ch_data,
    output logic [2:0]            cfg_addr,
    output logic                  cfg_coding,
    output logic [11:0]           ctrl_word,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sck_hist_r;
    logic                   cs_hist_r;

    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sck_rise_s;
    logic                   sck_fall_s;
    logic                   cs_rise_s;
    logic                   cs_fall_s;

    logic [0:0]             state_r;
    logic [4:0]             bit_cnt_r;
    logic [15:0]            tx_r;
    logic [11:0]            rx_r;
    logic                   miso_r;
    logic [2:0]             cfg_addr_r;
    logic                   cfg_coding_r;
    logic [11:0]            ctrl_word_r;
    logic                   frame_done_r;
    logic                   frame_err_r;

    logic [7:0]             conv_s;
    logic [15:0]            tx_next_s;

    // Input synchronizers plus one history flop per bus line for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync_r  <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sck_hist_r  <= 1'b0;
            cs_hist_r   <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], spi.spi_sck};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi.spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi.spi_mosi};
            sck_hist_r  <= sck_sync_r[SYNC_STAGES-1];
            cs_hist_r   <= cs_sync_r[SYNC_STAGES-1];
        end
    end

    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign cs_s       = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_hist_r;
    assign sck_fall_s = ~sck_s & sck_hist_r;
    assign cs_rise_s  = cs_s & ~cs_hist_r;
    assign cs_fall_s  = ~cs_s & cs_hist_r;

    // Conversion value for the latched channel; unmodelled addresses read as zero
    always_comb begin
        conv_s = 8'h00;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(cfg_addr_r) == k) begin
                conv_s = ch_data[8*k +: 8];
            end else begin
                conv_s = conv_s;
            end
        end
        if (!cfg_coding_r && (int'(cfg_addr_r) < NUM_CH)) begin
            conv_s = conv_s ^ 8'h80;
        end else begin
            conv_s = conv_s;
        end
    end

    assign tx_next_s = {1'b0, cfg_addr_r, conv_s, 4'b0000};

    // Frame FSM: CS_N rise takes priority over any SCK edge seen in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 5'd0;
            tx_r         <= 16'h0000;
            rx_r         <= 12'h000;
            miso_r       <= 1'b0;
            cfg_addr_r   <= 3'd0;
            cfg_coding_r <= 1'b1;
            ctrl_word_r  <= 12'h033;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    miso_r <= 1'b0;
                    if (cs_fall_s) begin
                        tx_r      <= tx_next_s;
                        miso_r    <= tx_next_s[15];
                        bit_cnt_r <= 5'd0;
                        rx_r      <= 12'h000;
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise_s) begin
                        miso_r  <= 1'b0;
                        state_r <= ST_IDLE;
                        if (bit_cnt_r == 5'd16) begin
                            frame_done_r <= 1'b1;
                            if (rx_r[11]) begin
                                ctrl_word_r  <= rx_r;
                                cfg_addr_r   <= rx_r[8:6];
                                cfg_coding_r <= rx_r[0];
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end else if (sck_rise_s) begin
                        if (bit_cnt_r < 5'd12) begin
                            rx_r <= {rx_r[10:0], mosi_s};
                        end
                        if (bit_cnt_r < 5'd16) begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end else if (sck_fall_s) begin
                        if (bit_cnt_r == 5'd16) begin
                            miso_r <= 1'b0;
                        end else if (bit_cnt_r != 5'd0) begin
                            miso_r <= tx_r[4'd15 - bit_cnt_r[3:0]];
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    miso_r  <= 1'b0;
                end
            endcase
        end
    end

    assign spi.spi_miso = miso_r;
    assign cfg_addr     = cfg_addr_r;
    assign cfg_coding   = cfg_coding_r;
    assign ctrl_word    = ctrl_word_r;
    assign frame_done   = frame_done_r;
    assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Self-checking bench for spi_adc_responder: bit-banged SPI master with a
// scoreboard of expected MISO frames built from a small configuration model.
module tb_spi_adc_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] ch_data;
    logic [2:0]  cfg_addr;
    logic        cfg_coding;
    logic [11:0] ctrl_word;
    logic        frame_done;
    logic        frame_err;

    spi_adc_responder_if bus ();

    spi_adc_responder #(.NUM_CH(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi        (bus),
        .ch_data    (ch_data),
        .cfg_addr   (cfg_addr),
        .cfg_coding (cfg_coding),
        .ctrl_word  (ctrl_word),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int err_cnt      = 0;

    logic [2:0]  m_addr;
    logic        m_coding;
    logic [15:0] sb_q[$];
    logic [31:0] last_cap;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI frame: push expected frame, clock it, pop and compare, check pulses.
    task automatic run_frame(input logic [11:0] word, input int nedges, input string name);
        logic [31:0] cap;
        logic [31:0] tail_mask;
        logic [15:0] exp_f;
        logic [7:0]  c;
        int d0;
        int e0;
        c = ch_data[8*m_addr +: 8];
        if (!m_coding) c = c ^ 8'h80;
        sb_q.push_back({1'b0, m_addr, c, 4'b0000});
        d0 = done_cnt;
        e0 = err_cnt;
        cap = 32'd0;
        bus.spi_cs_n = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < nedges; i++) begin
            bus.spi_mosi = (i < 12) ? word[11-i] : 1'b1;
            wait_cyc(6);
            cap = {cap[30:0], bus.spi_miso};
            bus.spi_sck = 1'b1;
            wait_cyc(6);
            bus.spi_sck = 1'b0;
        end
        wait_cyc(6);
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        wait_cyc(8);
        exp_f = sb_q.pop_front();
        last_cap = cap;
        if (nedges >= 16) begin
            tests_run++;
            if (cap[nedges-1 -: 16] !== exp_f) begin
                tests_failed++;
                $display("FAIL %s frame: got %h expected %h", name, cap[nedges-1 -: 16], exp_f);
            end
            if (nedges > 16) begin
                tail_mask = (32'd1 << (nedges - 16)) - 32'd1;
                tests_run++;
                if ((cap & tail_mask) !== 32'd0) begin
                    tests_failed++;
                    $display("FAIL %s tail bits: got %h expected 0", name, cap & tail_mask);
                end
            end
            tests_run++;
            if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin
                tests_failed++;
                $display("FAIL %s pulses: done %0d err %0d expected done 1 err 0", name, done_cnt - d0, err_cnt - e0);
            end
            if (word[11]) begin
                m_addr   = word[8:6];
                m_coding = word[0];
            end
        end else begin
            tests_run++;
            if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 1) begin
                tests_failed++;
                $display("FAIL %s pulses: done %0d err %0d expected done 0 err 1", name, done_cnt - d0, err_cnt - e0);
            end
        end
    endtask

    task automatic test_reset();
        int d0;
        int e0;
        ch_data = 64'h0;
        ch_data[7:0] = 8'hA5;
        bus.spi_sck = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        rst_n = 1'b0;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(4);
        m_addr = 3'd0;
        m_coding = 1'b1;
        tests_run++;
        if (bus.spi_miso !== 1'b0 || cfg_addr !== 3'd0 || cfg_coding !== 1'b1 || ctrl_word !== 12'h033) begin
            tests_failed++;
            $display("FAIL reset state: miso %b addr %0d coding %b ctrl %h expected 0 0 1 033", bus.spi_miso, cfg_addr, cfg_coding, ctrl_word);
        end
        tests_run++;
        if (done_cnt !== 0 || err_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset pulses: done %0d err %0d expected 0 0", done_cnt, err_cnt);
        end
        // Reset in the middle of a frame must abort it silently
        d0 = done_cnt;
        e0 = err_cnt;
        bus.spi_cs_n = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < 5; i++) begin
            bus.spi_mosi = 1'b1;
            wait_cyc(6);
            bus.spi_sck = 1'b1;
            wait_cyc(6);
            bus.spi_sck = 1'b0;
        end
        rst_n = 1'b0;
        wait_cyc(2);
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        wait_cyc(6);
        rst_n = 1'b1;
        wait_cyc(10);
        tests_run++;
        if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0 || ctrl_word !== 12'h033) begin
            tests_failed++;
            $display("FAIL reset midframe: done %0d err %0d ctrl %h expected 0 0 033", done_cnt - d0, err_cnt - e0, ctrl_word);
        end
    endtask

    task automatic test_write_pipeline();
        ch_data[7:0]  = 8'h3C;
        ch_data[15:8] = 8'hC3;
        run_frame(12'b1_0_0_001_11_0_0_11, 16, "pipe1");
        tests_run++;
        if (last_cap[15:0] !== 16'h03C0 || cfg_addr !== 3'd1 || ctrl_word !== 12'h873) begin
            tests_failed++;
            $display("FAIL pipe1 result: frame %h addr %0d ctrl %h expected 03C0 1 873", last_cap[15:0], cfg_addr, ctrl_word);
        end
        run_frame(12'h000, 16, "pipe2");
        tests_run++;
        if (last_cap[15:0] !== 16'h1C30 || cfg_addr !== 3'd1) begin
            tests_failed++;
            $display("FAIL pipe2 result: frame %h addr %0d expected 1C30 1", last_cap[15:0], cfg_addr);
        end
    endtask

    task automatic test_no_write();
        run_frame(12'h140, 16, "nowrite");
        tests_run++;
        if (ctrl_word !== 12'h873 || cfg_addr !== 3'd1) begin
            tests_failed++;
            $display("FAIL nowrite cfg: ctrl %h addr %0d expected 873 1", ctrl_word, cfg_addr);
        end
        run_frame(12'h000, 16, "nowrite_next");
        tests_run++;
        if (last_cap[15:0] !== 16'h1C30) begin
            tests_failed++;
            $display("FAIL nowrite_next frame: got %h expected 1C30", last_cap[15:0]);
        end
    endtask

    task automatic test_coding();
        ch_data[23:16] = 8'h10;
        run_frame(12'h880, 16, "coding_wr");
        tests_run++;
        if (cfg_coding !== 1'b0 || cfg_addr !== 3'd2) begin
            tests_failed++;
            $display("FAIL coding cfg: coding %b addr %0d expected 0 2", cfg_coding, cfg_addr);
        end
        run_frame(12'h000, 16, "coding_rd");
        tests_run++;
        if (last_cap[15:0] !== 16'h2900) begin
            tests_failed++;
            $display("FAIL coding frame: got %h expected 2900", last_cap[15:0]);
        end
    endtask

    task automatic test_abort();
        run_frame(12'h941, 9, "abort");
        tests_run++;
        if (cfg_addr !== 3'd2 || ctrl_word !== 12'h880) begin
            tests_failed++;
            $display("FAIL abort cfg: addr %0d ctrl %h expected 2 880", cfg_addr, ctrl_word);
        end
        run_frame(12'h000, 16, "abort_next");
        tests_run++;
        if (last_cap[15:0] !== 16'h2900) begin
            tests_failed++;
            $display("FAIL abort_next frame: got %h expected 2900", last_cap[15:0]);
        end
    endtask

    task automatic test_long_frame();
        run_frame(12'h841, 20, "long");
        tests_run++;
        if (last_cap[19:0] !== 20'h29000) begin
            tests_failed++;
            $display("FAIL long bits: got %h expected 29000", last_cap[19:0]);
        end
        tests_run++;
        if (ctrl_word !== 12'h841 || cfg_addr !== 3'd1 || cfg_coding !== 1'b1) begin
            tests_failed++;
            $display("FAIL long cfg: ctrl %h addr %0d coding %b expected 841 1 1", ctrl_word, cfg_addr, cfg_coding);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] w;
        for (int n = 0; n < 5; n++) begin
            ch_data = {$urandom, $urandom};
            w = 12'h800 | 12'($urandom_range(0, 7) << 6) | 12'($urandom_range(0, 1));
            run_frame(w, 16, "b2b");
            tests_run++;
            if (cfg_addr !== m_addr || cfg_coding !== m_coding || ctrl_word !== w) begin
                tests_failed++;
                $display("FAIL b2b cfg: addr %0d coding %b ctrl %h expected %0d %b %h", cfg_addr, cfg_coding, ctrl_word, m_addr, m_coding, w);
            end
        end
        run_frame(12'h000, 16, "b2b_last");
    endtask

    initial begin
        test_reset();
        test_write_pipeline();
        test_no_write();
        test_coding();
        test_abort();
        test_long_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
